// File: rtl/sisc_mc_ctrl.sv
// Multicycle control sequencer for the SISC core with ready/ack memory handshakes,
// a per-access wait timeout leading to a sticky fault, and a sticky halt.
module sisc_mc_ctrl #(
   parameter int unsigned OPC_W   = 4,
   parameter int unsigned MM_W    = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_f,
   input  logic [OPC_W-1:0] opcode,
   input  logic [MM_W-1:0]  mm,
   input  logic [MM_W-1:0]  stat,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             pc_rst,
   output logic             pc_write,
   output logic             pc_sel,
   output logic             br_sel,
   output logic             ir_load,
   output logic             rf_we,
   output logic             rb_sel,
   output logic             swap_sel,
   output logic             stat_en,
   output logic             addr_sel,
   output logic             dm_we,
   output logic [1:0]       alu_op,
   output logic [1:0]       wb_sel,
   output logic             halted,
   output logic             fault
);

   localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

   localparam logic [OPC_W-1:0] OpNop = OPC_W'(4'b0000);
   localparam logic [OPC_W-1:0] OpAlr = OPC_W'(4'b0001);
   localparam logic [OPC_W-1:0] OpAli = OPC_W'(4'b0010);
   localparam logic [OPC_W-1:0] OpBra = OPC_W'(4'b0100);
   localparam logic [OPC_W-1:0] OpBrr = OPC_W'(4'b0101);
   localparam logic [OPC_W-1:0] OpBne = OPC_W'(4'b0110);
   localparam logic [OPC_W-1:0] OpBnr = OPC_W'(4'b0111);
   localparam logic [OPC_W-1:0] OpLod = OPC_W'(4'b1000);
   localparam logic [OPC_W-1:0] OpStr = OPC_W'(4'b1001);
   localparam logic [OPC_W-1:0] OpSwp = OPC_W'(4'b1010);
   localparam logic [OPC_W-1:0] OpHlt = OPC_W'(4'b1111);

   typedef enum logic [3:0] {
      StStart, StFetch, StDecode, StExec, StMem, StWb, StSwap2, StHalt, StFault
   } state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] wait_q, wait_d;

   logic is_alu, is_br, is_mem, is_str, is_lod, is_swp, is_hlt, is_nop, legal;
   logic br_taken, cond_hit, timeout;

   assign is_alu = (opcode == OpAlr) || (opcode == OpAli);
   assign is_br  = (opcode == OpBra) || (opcode == OpBrr) || (opcode == OpBne) ||
                   (opcode == OpBnr);
   assign is_lod = (opcode == OpLod);
   assign is_str = (opcode == OpStr);
   assign is_mem = is_lod || is_str;
   assign is_swp = (opcode == OpSwp);
   assign is_hlt = (opcode == OpHlt);
   assign is_nop = (opcode == OpNop);
   assign legal  = is_alu || is_br || is_mem || is_swp || is_hlt || is_nop;

   // BRA/BRR treat an all-zero mask as unconditional; BNE/BNR invert the match.
   assign cond_hit = |(stat & mm);
   assign br_taken = ((opcode == OpBra) || (opcode == OpBrr)) ? ((mm == '0) || cond_hit)
                                                              : !cond_hit;

   assign timeout = (TIMEOUT != 0) && (wait_q == WaitLast);

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= StStart;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      ir_load  = 1'b0;
      rf_we    = 1'b0;
      rb_sel   = 1'b0;
      swap_sel = 1'b0;
      stat_en  = 1'b0;
      addr_sel = 1'b0;
      dm_we    = 1'b0;
      alu_op   = 2'b00;
      wb_sel   = 2'b00;
      halted   = 1'b0;
      fault    = 1'b0;
      unique case (state_q)
         StStart: begin
            pc_rst  = 1'b1;
            state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load  = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StDecode: begin
            rb_sel = is_str;
            if (!legal)      state_d = StFault;
            else if (is_hlt) state_d = StHalt;
            else if (is_nop) state_d = StFetch;
            else             state_d = StExec;
         end
         StExec: begin
            if (is_alu) begin
               alu_op  = (opcode == OpAli) ? 2'b10 : 2'b01;
               stat_en = 1'b1;
               state_d = StWb;
            end else if (is_mem) begin
               alu_op  = 2'b11;
               rb_sel  = is_str;
               state_d = StMem;
            end else if (is_br) begin
               if (br_taken) begin
                  pc_write = 1'b1;
                  pc_sel   = 1'b1;
                  br_sel   = (opcode == OpBrr) || (opcode == OpBnr);
               end
               state_d = StFetch;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            dmem_req = 1'b1;
            addr_sel = 1'b1;
            alu_op   = 2'b11;
            dm_we    = is_str;
            if (dmem_ack)     state_d = is_str ? StFetch : StWb;
            else if (timeout) state_d = StFault;
         end
         StWb: begin
            rf_we = 1'b1;
            if (is_alu)      alu_op = (opcode == OpAli) ? 2'b10 : 2'b01;
            else if (is_lod) wb_sel = 2'b01;
            else             wb_sel = 2'b10;
            state_d = is_swp ? StSwap2 : StFetch;
         end
         StSwap2: begin
            rf_we    = 1'b1;
            wb_sel   = 2'b11;
            swap_sel = 1'b1;
            state_d  = StFetch;
         end
         StHalt:  halted = 1'b1;
         StFault: fault  = 1'b1;
         default: state_d = StFault;
      endcase
   end

   // Counts unacknowledged request cycles; any state change restarts it from zero.
   always_comb begin
      wait_d = '0;
      if ((TIMEOUT != 0) && (state_d == state_q) &&
          (((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dmem_ack))) begin
         wait_d = wait_q + 1'b1;
      end
   end

endmodule
